alu_multicycle: RTL

//  Parametrised execute-stage ALU, successor to the single-cycle ALU.
//  - Adds iterative multiply/divide (MUL, MULHU, DIVU, REMU) and a clean, non-overlapping opcode map.
//  - Adds a valid/ready handshake on both sides so the control FSM can stall on multi-cycle ops.
//  - Sits between the register-read/immediate mux and the writeback mux.

---
 rtl/alu_multicycle.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle - execute-stage ALU with a valid/ready handshake on both sides.
//   Single-cycle ops finish one cycle after acceptance. MUL/MULHU/DIVU/REMU run
//   iteratively, one shift-add or restoring-subtract step per cycle.
// Ports:
//   clk, resetn       rising-edge clock, asynchronous active-low reset
//   flush             synchronous abort of any in-flight op (dropping a same-cycle offer)
//   in_valid/in_ready input handshake; in_ready is high only in IDLE
//   aluControl        5-bit opcode
//   srcA, srcB        operands, registered at acceptance
//   out_valid         result valid (DONE); out_ready consumes it
//   aluResult         registered result, held until the next completed op
//   busy              high whenever the ALU is not IDLE
// DEBUG is accepted for build compatibility. Transfer tracing lives in the
// simulation environment, not in this synthesizable file.
module alu_multicycle #(
   parameter int WIDTH     = 32,
   parameter int MULDIV_EN = 1,
   parameter int DEBUG     = 0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       aluControl,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] aluResult,
   output logic             busy
);

   localparam int SHW  = $clog2(WIDTH);
   localparam int CNTW = SHW + 1;

   if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0 || DEBUG < 0 || DEBUG > 1) begin : gBadParams
      $error("alu_multicycle: unsupported parameter set");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state, stateNext;
   logic [CNTW-1:0]    cnt;
   logic [4:0]         opReg;
   logic [WIDTH-1:0]   bReg;
   // MUL: {partial product, remaining multiplier}; DIV: {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] acc, accNext;
   logic [WIDTH-1:0]   scResult;
   logic [SHW-1:0]     shamt;
   logic               isMulDiv, divByZero, goMulti, lastStep;
   logic [WIDTH:0]     mulSum, divShift, divDiff;

   function automatic logic [WIDTH-1:0] zext(input logic b);
      return {{(WIDTH-1){1'b0}}, b};
   endfunction

   assign shamt     = srcB[SHW-1:0];
   assign isMulDiv  = (aluControl[4:2] == 3'b100);
   assign divByZero = aluControl[1] && (srcB == '0);
   assign goMulti   = isMulDiv && (MULDIV_EN != 0) && !divByZero;
   assign lastStep  = (cnt == CNTW'(1));

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // Single-cycle results; also covers divide-by-zero and the no-muldiv build.
   always_comb begin
      scResult = '0;
      unique case (aluControl)
         5'h00: scResult = srcA + srcB;
         5'h01: scResult = srcA - srcB;
         5'h02: scResult = srcA & srcB;
         5'h03: scResult = $signed(srcA) >>> shamt;
         5'h04: scResult = srcA | srcB;
         5'h05: scResult = zext($signed(srcA) < $signed(srcB));
         5'h06: scResult = srcA ^ srcB;
         5'h07: scResult = srcA << shamt;
         5'h08: scResult = srcA >> shamt;
         5'h09: scResult = zext(srcA == srcB);
         5'h0A: scResult = zext(srcA != srcB);
         5'h0B: scResult = zext(srcA < srcB);
         5'h0C: scResult = zext(srcA >= srcB);
         5'h0D: scResult = zext($signed(srcA) >= $signed(srcB));
         5'h0E: scResult = srcB;
         5'h12: scResult = (MULDIV_EN != 0) ? '1 : '0;
         5'h13: scResult = (MULDIV_EN != 0) ? srcA : '0;
         default: scResult = '0;
      endcase
   end

   // One iteration step. divDiff[WIDTH] is the borrow: remainder < divisor keeps
   // the shifted value below 2*divisor, so WIDTH+1 bits suffice.
   always_comb begin
      mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bReg} : '0);
      divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      divDiff  = divShift - {1'b0, bReg};
      accNext  = acc;
      if (!opReg[1])
         accNext = {mulSum, acc[WIDTH-1:1]};
      else if (!divDiff[WIDTH])
         accNext = {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         accNext = {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE: if (in_valid) stateNext = goMulti ? BUSY : DONE;
         BUSY: if (lastStep) stateNext = DONE;
         DONE: if (out_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      if (flush) stateNext = IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt       <= '0;
         opReg     <= '0;
         bReg      <= '0;
         acc       <= '0;
         aluResult <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               opReg <= aluControl;
               bReg  <= srcB;
               if (goMulti) begin
                  acc <= {{WIDTH{1'b0}}, srcA};
                  cnt <= CNTW'(WIDTH);
               end else begin
                  aluResult <= scResult;
               end
            end
            BUSY: begin
               acc <= accNext;
               cnt <= cnt - CNTW'(1);
               // MULHU/REMU take the upper half, MUL/DIVU the lower half.
               if (lastStep)
                  aluResult <= opReg[0] ? accNext[2*WIDTH-1:WIDTH] : accNext[WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule
